instr_fetch_queue: RTL

//   Sits directly downstream of the fetch stage. Takes each 8-bit PC it produces, issues a read
//   to synchronous instruction memory, and buffers returned {pc, instr} pairs in a small FIFO.

---
 rtl/ifq_pkg.sv | 17 +
 rtl/ifq_if.sv | 28 ++
 rtl/ifq_fifo.sv | 50 +++++
 rtl/instr_fetch_queue.sv | 74 +++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// Shared widths and the {pc, instr} entry type for the instruction fetch queue.
// Optional combinational return bypass is enabled by defining IFQ_BYPASS_EN.
package ifq_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W   = CNT_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_if.sv
// Fetch-side, memory-side and decode-side signals of the instruction fetch queue.
interface ifq_if;
  import ifq_pkg::*;

  logic [ADDR_W-1:0]  pc_i;
  logic               pc_valid_i;
  logic               pc_ready_o;
  logic               flush_i;
  logic [ADDR_W-1:0]  imem_addr_o;
  logic               imem_rd_o;
  logic [INSTR_W-1:0] imem_data_i;
  logic [INSTR_W-1:0] instr_o;
  logic [ADDR_W-1:0]  instr_pc_o;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic [CNT_W-1:0]   count_o;

  modport slave (
    input  pc_i, pc_valid_i, flush_i, imem_data_i, instr_ready_i,
    output pc_ready_o, imem_addr_o, imem_rd_o, instr_o, instr_pc_o, instr_valid_o, count_o
  );

  modport master (
    output pc_i, pc_valid_i, flush_i, imem_data_i, instr_ready_i,
    input  pc_ready_o, imem_addr_o, imem_rd_o, instr_o, instr_pc_o, instr_valid_o, count_o
  );

endinterface

// File: rtl/ifq_fifo.sv
// DEPTH-entry FIFO of {pc, instr} pairs with push/pop and a synchronous clear.
module ifq_fifo
  import ifq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  ifq_entry_t       push_data,
  input  logic             pop,
  output ifq_entry_t       head,
  output logic [CNT_W-1:0] count
);

  ifq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Clear only resets occupancy; stale storage is unreachable once count is zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Issues fetch PCs to synchronous instruction memory and queues returned {pc, instr} for decode.
// Define IFQ_BYPASS_EN to forward a return straight to decode when the queue is empty.
module instr_fetch_queue
  import ifq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  ifq_if.slave bus
);

  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [CNT_W-1:0]  count;
  logic [OCC_W-1:0]  occupancy;
  logic              accept;
  logic              head_valid;
  logic              push;
  logic              pop;
  ifq_entry_t        head;
  ifq_entry_t        wr_entry;

  // In-flight reads reserve a slot so a return always has somewhere to land.
  assign occupancy      = OCC_W'(count) + OCC_W'(inflight);
  assign bus.pc_ready_o = !bus.flush_i && (occupancy < OCC_W'(DEPTH));
  assign accept         = bus.pc_valid_i && bus.pc_ready_o;
  assign bus.imem_rd_o  = accept;
  assign bus.imem_addr_o = bus.pc_i;
  assign bus.count_o    = count;
  assign head_valid     = (count != '0);
  assign wr_entry       = '{pc: inflight_pc, instr: bus.imem_data_i};

`ifdef IFQ_BYPASS_EN
  logic bypass_valid;

  assign bypass_valid      = inflight && !head_valid && !bus.flush_i;
  assign bus.instr_valid_o = head_valid || bypass_valid;
  assign bus.instr_o       = head_valid ? head.instr : bus.imem_data_i;
  assign bus.instr_pc_o    = head_valid ? head.pc    : inflight_pc;
  assign pop               = head_valid && bus.instr_ready_i;
  // A return consumed directly by decode is never written.
  assign push              = inflight && !bus.flush_i && !(bypass_valid && bus.instr_ready_i);
`else
  assign bus.instr_valid_o = head_valid;
  assign bus.instr_o       = head.instr;
  assign bus.instr_pc_o    = head.pc;
  assign pop               = head_valid && bus.instr_ready_i;
  assign push              = inflight && !bus.flush_i;
`endif

  // In-flight read tracking: set on accept, dropped by flush or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_pc <= bus.pc_i;
      end
    end
  end

  ifq_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.flush_i),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule
